updown_gray_counter: RTL
========================

UPDOWN_GRAY_COUNTER -- requirements
Module: updown_gray_counter

Interface
REQ-001 Parameter WIDTH, default 3, SHALL set the counter width in bits (legal range 2..16).
REQ-002 Parameter SATURATE, default 0, SHALL select the end-of-range behaviour: 0 = wrap, 1 = hold at limit.
REQ-003 clck  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rset  in  1  SHALL be the asynchronous, active-low reset (0 = reset asserted).
REQ-005 en  in  1  SHALL be the count enable (1 = step one position per edge).
REQ-006 up  in  1  SHALL be the direction select (1 = increment, 0 = decrement).
REQ-007 load  in  1  SHALL be the synchronous parallel load strobe.
REQ-008 d  in  WIDTH  SHALL be the binary load value.
REQ-009 gray_sel  in  1  SHALL be the output code select (0 = binary, 1 = Gray).
REQ-010 cnt  out  WIDTH  SHALL be the internal binary count register.
REQ-011 q  out  WIDTH  SHALL be the coded count: cnt when gray_sel=0, cnt XOR (cnt >> 1) when gray_sel=1.
REQ-012 tc  out  1  SHALL be the registered terminal-count pulse.

Function
REQ-013 The block SHALL apply priority per edge: load > en > hold.
REQ-014 load=1 SHALL set cnt <= d on the next edge regardless of en, up and SATURATE.
REQ-015 load=0, en=0 SHALL hold cnt.
REQ-016 load=0, en=1, up=1 SHALL set cnt <= cnt+1 modulo 2^WIDTH when SATURATE=0.
REQ-017 load=0, en=1, up=0 SHALL set cnt <= cnt-1 modulo 2^WIDTH when SATURATE=0.
REQ-018 With SATURATE=1, cnt SHALL hold at 2^WIDTH-1 when counting up and at 0 when counting down; no wrap.
REQ-019 q SHALL be combinational from cnt and gray_sel, so a gray_sel change is visible in the same cycle with no added latency.
REQ-020 A change of up SHALL take effect on the next enabled edge; no idle cycle.
REQ-021 With SATURATE=0, tc SHALL be 1 for exactly the cycle after an enabled edge that wraps cnt, either up from 2^WIDTH-1 to 0 or down from 0 to 2^WIDTH-1; otherwise tc SHALL be 0.
REQ-022 With SATURATE=1, tc SHALL be 1 for the cycle after the enabled edge on which cnt first reaches its limit from a non-limit value.
REQ-023 With SATURATE=1, tc SHALL stay 0 while cnt holds at the limit.
REQ-024 A load edge SHALL clear tc, even if d equals a limit value.
REQ-025 Counting by one SHALL change exactly one bit of q per enabled step when gray_sel=1, including across the wrap boundary.

Reset
REQ-026 rset=0 SHALL immediately, without a clock edge, force cnt=0, tc=0 and therefore q=0 in both codes.
REQ-027 Reset asserted mid-count or during load SHALL override all inputs.
REQ-028 After rset returns to 1, the first rising edge SHALL evaluate inputs normally from cnt=0.

Verification
REQ-029 WIDTH=3, SATURATE=0, reset then en=1, up=1 for 9 edges -> cnt 1,2,..,7,0,1; tc=1 only in the cycle after 7->0.
REQ-030 WIDTH=3, gray_sel=1, up count from 0 -> q 000,001,011,010,110,111,101,100,000; one bit changes per step.
REQ-031 WIDTH=3, SATURATE=1, load d=5 then en=1, up=1 for 4 edges -> cnt 6,7,7,7; tc=1 only in the cycle after 6->7.
REQ-032 WIDTH=3, SATURATE=0, cnt=0, en=1, up=0 -> cnt=7 and tc=1 in the next cycle.
REQ-033 load=1 and en=1 together with d=3, cnt=6 -> cnt=3, tc=0 on the next edge.
REQ-034 Drive rset=0 between edges with cnt=4 -> cnt=0, q=0, tc=0 immediately; release and count up -> first edge gives cnt=1.

Source files
------------

// File: rtl/updown_gray_counter.sv
// ---------------------------------------------------------------------------
// updown_gray_counter
//
// Purpose:
//   Up/down binary counter with a parallel load, an optional saturating mode,
//   a registered terminal-count pulse and a selectable binary/Gray output.
//
// Parameters:
//   WIDTH     counter width in bits (2..16)
//   SATURATE  0 = wrap at the ends of the range, 1 = hold at the limit
//
// Ports:
//   clck      in   1      clock, all state changes on its rising edge
//   rset      in   1      asynchronous active-low reset
//   en        in   1      count enable, one step per edge
//   up        in   1      direction (1 = increment, 0 = decrement)
//   load      in   1      synchronous parallel load strobe (beats en)
//   d         in   WIDTH  binary load value
//   gray_sel  in   1      output code select (0 = binary, 1 = Gray)
//   cnt       out  WIDTH  binary count register
//   q         out  WIDTH  cnt in the selected code (combinational)
//   tc        out  1      registered terminal-count pulse
// ---------------------------------------------------------------------------
module updown_gray_counter #(
  parameter int WIDTH    = 3,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clck,
  input  logic             rset,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic             gray_sel,
  output logic [WIDTH-1:0] cnt,
  output logic [WIDTH-1:0] q,
  output logic             tc
);

  localparam logic [WIDTH-1:0] MAX_VAL  = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] MIN_VAL  = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_VAL  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] MAXM1_VAL = MAX_VAL - ONE_VAL;

  logic [WIDTH-1:0] cnt_reg;
  logic [WIDTH-1:0] cnt_next;
  logic             tc_reg;
  logic             tc_next;
  logic [WIDTH-1:0] gray;

  logic at_max;
  logic at_min;
  logic near_max;
  logic near_min;

  assign at_max   = (cnt_reg == MAX_VAL);
  assign at_min   = (cnt_reg == MIN_VAL);
  assign near_max = (cnt_reg == MAXM1_VAL);
  assign near_min = (cnt_reg == ONE_VAL);

  // Next-state: load beats count, count beats hold. tc is a one-cycle pulse,
  // so every path that is not a qualifying count step drives it low.
  always_comb begin
    cnt_next = cnt_reg;
    tc_next  = 1'b0;
    if (load) begin
      cnt_next = d;
    end else if (en) begin
      if (up) begin
        if (!(SATURATE && at_max)) begin
          cnt_next = cnt_reg + ONE_VAL;
        end
        // Wrap mode flags the max->0 roll-over; saturate mode flags the
        // step that first lands on the limit, never the holding steps.
        tc_next = SATURATE ? near_max : at_max;
      end else begin
        if (!(SATURATE && at_min)) begin
          cnt_next = cnt_reg - ONE_VAL;
        end
        tc_next = SATURATE ? near_min : at_min;
      end
    end
  end

  always_ff @(posedge clck or negedge rset) begin
    if (!rset) begin
      cnt_reg <= MIN_VAL;
      tc_reg  <= 1'b0;
    end else begin
      cnt_reg <= cnt_next;
      tc_reg  <= tc_next;
    end
  end

  // Binary-to-Gray: each bit is the XOR with its upper neighbour; the MSB
  // passes through unchanged.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH - 1; gi = gi + 1) begin : g_gray
      assign gray[gi] = cnt_reg[gi] ^ cnt_reg[gi+1];
    end
  endgenerate
  assign gray[WIDTH-1] = cnt_reg[WIDTH-1];

  assign cnt = cnt_reg;
  assign q   = gray_sel ? gray : cnt_reg;
  assign tc  = tc_reg;

endmodule
